// File: rtl/inferno_stick_mapper.sv
// ---------------------------------------------------------------------------
// inferno_stick_mapper
//
// Purpose:
//   Turns one MiSTer stick (digital d-pad word plus a signed analog X/Y word)
//   into a registered 4-bit direction word for one williams2 stick input
//   (btn_run_1/2 or btn_aim_1/2). The Inferno top level uses four of these:
//   P1 run, P1 aim, P2 run, P2 aim.
//
//   Analog path: each axis has a NEUTRAL/POS/NEG state machine with
//   hysteresis (ON_TH to enter, OFF_TH to leave). A stability filter only
//   commits a new state once it has been seen on STABLE consecutive sample
//   ticks. Digital path: the d-pad is passed straight through, except that
//   opposite directions pressed together cancel each other.
//   A pressed d-pad always wins over the analog stick.
//
// Ports:
//   clk_sys        in   1   system clock (12 MHz)
//   reset_n        in   1   synchronous, active-low reset
//   joy_dig        in   4   d-pad: [0] right, [1] left, [2] down, [3] up
//   joy_ana        in  16   [7:0] X signed (neg = left), [15:8] Y signed (neg = up)
//   dir            out  4   direction word, same bit order as joy_dig
//   analog_active  out  1   dir is currently sourced from a deflected analog stick
//   tick           out  1   one-cycle sample strobe, every DIV cycles
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module inferno_stick_mapper #(
  parameter int ON_TH  = 48,     // magnitude that enters a deflected state
  parameter int OFF_TH = 32,     // magnitude below which the axis returns to neutral
  parameter int STABLE = 3,      // ticks a new state must persist (1..15)
  parameter int DIV    = 12000   // clk_sys cycles per sample tick (>= 2)
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [3:0]  joy_dig,
  input  logic [15:0] joy_ana,
  output logic [3:0]  dir,
  output logic        analog_active,
  output logic        tick
);

  localparam int CNT_W = $clog2(DIV);

  // Thresholds as 9-bit signed values so -128 compares correctly.
  localparam logic signed [8:0] ON_POS  = 9'(ON_TH);
  localparam logic signed [8:0] ON_NEG  = -9'(ON_TH);
  localparam logic signed [8:0] OFF_POS = 9'(OFF_TH);
  localparam logic signed [8:0] OFF_NEG = -9'(OFF_TH);
  localparam logic [3:0]        STABLE_V = 4'(STABLE);

  typedef enum logic [1:0] {
    AX_NEUTRAL = 2'd0,
    AX_POS     = 2'd1,
    AX_NEG     = 2'd2
  } axis_state_e;

  // -------------------------------------------------------------------------
  // Sample prescaler
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q, tick_d;
  logic             tick_en;

  // The axis logic acts on the same edge that raises tick_q, so a committed
  // state change is visible during the tick cycle and reaches dir one cycle
  // later.
  assign tick_en = (pre_cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    pre_cnt_d = pre_cnt_q + CNT_W'(1);
    tick_d    = 1'b0;
    if (tick_en) begin
      pre_cnt_d = '0;
      tick_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-axis hysteresis state machine and stability filter.
  // gi = 0 is X (POS = right), gi = 1 is Y (POS = down).
  // -------------------------------------------------------------------------
  logic [1:0] ana_pos;
  logic [1:0] ana_neg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_axis
      axis_state_e       state_q, state_d;   // committed state
      axis_state_e       cand_q, cand_d;     // candidate awaiting stability
      axis_state_e       raw_state;          // hysteresis result for this tick
      logic [3:0]        stab_q, stab_d;
      logic [3:0]        stab_n;
      logic signed [8:0] ax_val;
      logic              pos_b, neg_b;

      assign ax_val = {joy_ana[gi*8 + 7], joy_ana[gi*8 +: 8]};

      // State register (committed state, candidate and stability counter).
      always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
          state_q <= AX_NEUTRAL;
          cand_q  <= AX_NEUTRAL;
          stab_q  <= 4'd0;
        end else begin
          state_q <= state_d;
          cand_q  <= cand_d;
          stab_q  <= stab_d;
        end
      end

      // Hysteresis: the thresholds applied depend on the committed state.
      // A full deflection the other way reverses directly without passing
      // through NEUTRAL.
      always_comb begin
        raw_state = AX_NEUTRAL;
        case (state_q)
          AX_NEUTRAL: begin
            if (ax_val >= ON_POS)      raw_state = AX_POS;
            else if (ax_val <= ON_NEG) raw_state = AX_NEG;
            else                       raw_state = AX_NEUTRAL;
          end
          AX_POS: begin
            if (ax_val <= ON_NEG)       raw_state = AX_NEG;
            else if (ax_val < OFF_POS)  raw_state = AX_NEUTRAL;
            else                        raw_state = AX_POS;
          end
          AX_NEG: begin
            if (ax_val >= ON_POS)       raw_state = AX_POS;
            else if (ax_val > OFF_NEG)  raw_state = AX_NEUTRAL;
            else                        raw_state = AX_NEG;
          end
          default: raw_state = AX_NEUTRAL;
        endcase
      end

      // Next-state: stability filter, only on sample ticks.
      always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        stab_n  = 4'd0;
        if (tick_en) begin
          if (raw_state == state_q) begin
            // Input agrees with what is committed: drop any pending change.
            cand_d = state_q;
            stab_d = 4'd0;
          end else begin
            if (raw_state != cand_q) begin
              cand_d = raw_state;
              stab_n = 4'd1;
            end else if (stab_q >= STABLE_V) begin
              stab_n = STABLE_V;
            end else begin
              stab_n = stab_q + 4'd1;
            end
            // Commit on the tick the count reaches STABLE (first tick when
            // STABLE is 1).
            if (stab_n >= STABLE_V) begin
              state_d = cand_d;
              stab_d  = 4'd0;
            end else begin
              stab_d  = stab_n;
            end
          end
        end
      end

      // Output decode of the committed state.
      always_comb begin
        pos_b = (state_q == AX_POS);
        neg_b = (state_q == AX_NEG);
      end

      assign ana_pos[gi] = pos_b;
      assign ana_neg[gi] = neg_b;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Direction words and source select
  // -------------------------------------------------------------------------
  logic [3:0] ana_dir;
  logic [3:0] dig_dir;
  logic [3:0] dir_q, dir_d;
  logic       analog_active_q, analog_active_d;

  // {up, down, left, right} = {Y NEG, Y POS, X NEG, X POS}
  assign ana_dir = {ana_neg[1], ana_pos[1], ana_neg[0], ana_pos[0]};

  // Opposite d-pad directions pressed together cancel.
  always_comb begin
    dig_dir[0] = joy_dig[0] & ~joy_dig[1];
    dig_dir[1] = joy_dig[1] & ~joy_dig[0];
    dig_dir[2] = joy_dig[2] & ~joy_dig[3];
    dig_dir[3] = joy_dig[3] & ~joy_dig[2];
  end

  // Any raw d-pad bit selects the digital path, even if the cancelled result
  // is zero; the analog machines keep running underneath.
  always_comb begin
    dir_d           = ana_dir;
    analog_active_d = |ana_dir;
    if (|joy_dig) begin
      dir_d           = dig_dir;
      analog_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dir_q           <= 4'd0;
      analog_active_q <= 1'b0;
    end else begin
      dir_q           <= dir_d;
      analog_active_q <= analog_active_d;
    end
  end

  assign dir           = dir_q;
  assign analog_active = analog_active_q;
  assign tick          = tick_q;

endmodule

// File: tb/tb_inferno_stick_mapper.sv
// ---------------------------------------------------------------------------
// tb_inferno_stick_mapper
//
// Bench for inferno_stick_mapper with DIV=4, STABLE=3. Expected direction
// words are queued when stimulus is applied and compared when the DUT is
// sampled. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_inferno_stick_mapper;

  localparam int DIV    = 4;
  localparam int STABLE = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  joy_dig = 4'd0;
  logic [15:0] joy_ana = 16'd0;
  logic [3:0]  dir;
  logic        analog_active;
  logic        tick;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    string      tag;
    logic [3:0] dir;
    logic       aa;
  } exp_t;

  exp_t sb_q[$];

  inferno_stick_mapper #(
    .ON_TH (48),
    .OFF_TH(32),
    .STABLE(STABLE),
    .DIV   (DIV)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .joy_dig      (joy_dig),
    .joy_ana      (joy_ana),
    .dir          (dir),
    .analog_active(analog_active),
    .tick         (tick)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic push(input string tag, input logic [3:0] d, input logic a);
    exp_t e;
    e.tag = tag;
    e.dir = d;
    e.aa  = a;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 8'(sb_q.size()), 8'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_dir"}, 8'(dir), 8'(e.dir));
      chk({e.tag, "_aa"}, 8'(analog_active), 8'(e.aa));
    end
  endtask

  // Advance to the next falling edge at which tick is high (bounded).
  task automatic wait_tick();
    int n;
    step();
    n = 1;
    while (tick !== 1'b1 && n < 3 * DIV) begin
      step();
      n++;
    end
    if (tick !== 1'b1) chk("tick_timeout", 8'(tick), 8'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Apply an analog value and expect the old direction through STABLE ticks,
  // then the new one exactly one cycle after the committing tick.
  task automatic ana_commit(input string tag, input logic [15:0] ana,
                            input logic [3:0] old_d, input logic [3:0] new_d);
    joy_ana = ana;
    for (int i = 0; i < STABLE; i++) begin
      push({tag, "_hold"}, old_d, old_d != 4'd0);
      wait_tick();
      pop_check();
    end
    push(tag, new_d, new_d != 4'd0);
    step();
    pop_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) step();
    push("reset", 4'd0, 1'b0);
    pop_check();
    chk("reset_tick", 8'(tick), 8'd0);
    reset_n = 1'b1;

    // Digital priority and opposite-direction cancel
    joy_dig = 4'b1000;
    joy_ana = 16'h0060;
    push("dig_up", 4'b1000, 1'b0);
    step();
    pop_check();
    joy_dig = 4'b0011;
    push("dig_rl", 4'b0000, 1'b0);
    step();
    pop_check();
    joy_dig = 4'b1100;
    push("dig_ud", 4'b0000, 1'b0);
    step();
    pop_check();
    joy_dig = 4'b0101;
    push("dig_rd", 4'b0101, 1'b0);
    step();
    pop_check();
    joy_dig = 4'd0;
    joy_ana = 16'd0;

    // Hysteresis on X
    do_reset();
    joy_ana = 16'h002F;                       // X = 47
    for (int i = 0; i < 10; i++) begin
      push("x47", 4'd0, 1'b0);
      wait_tick();
      pop_check();
    end
    ana_commit("x48", 16'h0030, 4'b0000, 4'b0001);
    joy_ana = 16'h0021;                       // X = 33
    for (int i = 0; i < 5; i++) begin
      push("x33", 4'b0001, 1'b1);
      wait_tick();
      pop_check();
    end
    ana_commit("x31", 16'h001F, 4'b0001, 4'b0000);

    // Glitch rejection
    wait_tick();
    for (int i = 0; i < 20; i++) begin
      joy_ana = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      push("glitch", 4'd0, 1'b0);
      wait_tick();
      pop_check();
    end
    joy_ana = 16'h0040;
    for (int i = 0; i < 2; i++) begin
      push("short64", 4'd0, 1'b0);
      wait_tick();
      pop_check();
    end
    joy_ana = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      push("after64", 4'd0, 1'b0);
      wait_tick();
      pop_check();
    end

    // Extreme values and direct reversal
    ana_commit("y_m128", 16'h8000, 4'b0000, 4'b1000);
    ana_commit("y_p127", 16'h7F00, 4'b1000, 4'b0100);

    // Diagonal and d-pad handover
    ana_commit("diag", 16'hB050, 4'b0100, 4'b1001);
    joy_dig = 4'b0010;
    push("dpad_left", 4'b0010, 1'b0);
    step();
    pop_check();
    joy_dig = 4'b0000;
    push("release", 4'b1001, 1'b1);
    step();
    pop_check();

    // Reset in the middle of the stability filter
    joy_ana = 16'h0064;                       // X = 100
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push("pre_rst", 4'd0, 1'b0);
      wait_tick();
      pop_check();
    end
    reset_n = 1'b0;
    step();
    push("mid_rst", 4'd0, 1'b0);
    pop_check();
    chk("mid_rst_tick", 8'(tick), 8'd0);
    reset_n = 1'b1;
    for (int c = 1; c <= DIV; c++) begin
      step();
      chk($sformatf("first_tick_c%0d", c), 8'(tick), (c == DIV) ? 8'd1 : 8'd0);
    end
    push("post_rst_t1", 4'd0, 1'b0);
    pop_check();
    for (int i = 2; i <= STABLE; i++) begin
      push($sformatf("post_rst_t%0d", i), 4'd0, 1'b0);
      wait_tick();
      pop_check();
    end
    push("post_rst_commit", 4'b0001, 1'b1);
    step();
    pop_check();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
